// File: rtl/pipe_stage_buf.sv
// Multi-lane pipeline register with valid/ready handshake and optional skid entry.
// Define PIPE_STAGE_BUF_STATS_EN to build the back-pressure cycle counter.
package global_pkg;
    typedef struct packed {
        logic Clk;
        logic Rst;
    } global_t;
endpackage

module pipe_stage_buf
    import global_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input  global_t                  System,
    input  logic                     Flush,
    input  logic                     Stall,
    input  logic [LANES-1:0]         In_Valid,
    input  logic [LANES*WIDTH-1:0]   In_Data,
    output logic                     In_Ready,
    output logic [LANES-1:0]         Out_Valid,
    output logic [LANES*WIDTH-1:0]   Out_Data,
    input  logic                     Out_Ready,
    output logic [31:0]              Stall_Cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic clk;
    assign clk = System.Clk;

    state_t                 state;
    logic [LANES-1:0]       head_v;
    logic [LANES-1:0]       skid_v;
    logic [LANES*WIDTH-1:0] head_d;
    logic [LANES*WIDTH-1:0] skid_d;
    logic [LANES*WIDTH-1:0] in_masked;
    logic                   push;
    logic                   pop;

    // Invalid lanes are stored as zero so idle output lanes always read 0.
    always_comb begin
        in_masked = '0;
        for (int i = 0; i < LANES; i++) begin
            if (In_Valid[i]) begin
                in_masked[i*WIDTH +: WIDTH] = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        unique case (state)
            FULL:    In_Ready = 1'b0;
            HALF:    In_Ready = (DEPTH == 1) ? (Out_Ready & ~Stall) : ~Stall;
            default: In_Ready = ~Stall;
        endcase
    end

    assign push = In_Ready & (|In_Valid);
    assign pop  = Out_Ready & (|head_v) & ~Stall;

    always_ff @(posedge clk) begin
        if (System.Rst || Flush) begin
            state  <= EMPTY;
            head_v <= '0;
            head_d <= '0;
            skid_v <= '0;
            skid_d <= '0;
        end else if (!Stall) begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head_v <= In_Valid;
                        head_d <= in_masked;
                        state  <= HALF;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        head_v <= In_Valid;
                        head_d <= in_masked;
                    end else if (push && DEPTH > 1) begin
                        skid_v <= In_Valid;
                        skid_d <= in_masked;
                        state  <= FULL;
                    end else if (pop) begin
                        head_v <= '0;
                        head_d <= '0;
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_v <= skid_v;
                        head_d <= skid_d;
                        skid_v <= '0;
                        skid_d <= '0;
                        state  <= HALF;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign Out_Valid = head_v;
    assign Out_Data  = head_d;

`ifdef PIPE_STAGE_BUF_STATS_EN
    // Counts cycles where upstream offered a bundle but was held off; saturating.
    always_ff @(posedge clk) begin
        if (System.Rst) begin
            Stall_Cnt <= '0;
        end else if ((|In_Valid) && !In_Ready && (Stall_Cnt != 32'hFFFF_FFFF)) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
        end
    end
`else
    assign Stall_Cnt = '0;
`endif

endmodule
